// File: rtl/block_mux_pipe_if.sv
// Valid/ready channel bundle for block_mux_pipe: packed input channels and
// select on the upstream side, one selected word and its index downstream.
interface block_mux_pipe_if #(
  parameter  int SEL_WIDTH  = 2,
  parameter  int DATA_WIDTH = 8,
  localparam int N_CH       = 1 << SEL_WIDTH
);
  logic [N_CH*DATA_WIDTH-1:0] I;
  logic [SEL_WIDTH-1:0]       I_sel;
  logic                       i_valid;
  logic                       o_ready;
  logic [DATA_WIDTH-1:0]      o;
  logic [SEL_WIDTH-1:0]       o_sel;
  logic                       o_valid;
  logic                       i_ready;

  // Traffic source/sink side (drives channels and consumes the result).
  modport master (
    output I, I_sel, i_valid, i_ready,
    input  o_ready, o, o_sel, o_valid
  );

  // Multiplexer side.
  modport slave (
    input  I, I_sel, i_valid, i_ready,
    output o_ready, o, o_sel, o_valid
  );
endinterface

// File: rtl/block_mux_pipe.sv
// Pipelined N-to-1 multiplexer tree. Each tree level halves the word count
// using one select bit (LSB first) and is followed by a register stage, so a
// word needs SEL_WIDTH cycles to reach the output. Every stage carries its
// own valid bit; a stage may load whenever it is empty or the stage after it
// advances, which squeezes bubbles out under backpressure.
module block_mux_pipe #(
  parameter  int SEL_WIDTH  = 2,
  parameter  int DATA_WIDTH = 8,
  localparam int N_CH       = 1 << SEL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  block_mux_pipe_if.slave   bus
);

  // Word offset of tree level k inside the flat tree vector. Level 0 is the
  // raw input (N_CH words), level k holds N_CH >> k words.
  function automatic int lvl_off(input int k);
    int s;
    s = 0;
    for (int m = 0; m < k; m++) s += N_CH >> m;
    return s;
  endfunction

  localparam int TREE_W  = (2 * N_CH - 1) * DATA_WIDTH;
  localparam int OUT_OFF = lvl_off(SEL_WIDTH) * DATA_WIDTH;

  // All tree levels packed back to back; level 0 comes straight from I.
  logic [TREE_W-1:0]    tree;
  logic [SEL_WIDTH-1:0] lvl_sel [SEL_WIDTH+1];
  logic                 lvl_v   [SEL_WIDTH+1];
  // adv[k]: stage k may load this cycle; adv[SEL_WIDTH+1] is the sink.
  logic                 adv     [1:SEL_WIDTH+1];

  assign tree[0 +: N_CH*DATA_WIDTH] = bus.I;
  assign lvl_sel[0]                 = bus.I_sel;
  assign lvl_v[0]                   = bus.i_valid;
  assign adv[SEL_WIDTH+1]           = bus.i_ready;

  assign bus.o_ready = adv[1];
  assign bus.o       = tree[OUT_OFF +: DATA_WIDTH];
  assign bus.o_sel   = lvl_sel[SEL_WIDTH];
  assign bus.o_valid = lvl_v[SEL_WIDTH];

  for (genvar k = 1; k <= SEL_WIDTH; k++) begin : g_stage
    localparam int WORDS  = N_CH >> k;
    localparam int IN_OFF = lvl_off(k - 1) * DATA_WIDTH;
    localparam int Q_OFF  = lvl_off(k) * DATA_WIDTH;

    logic [WORDS*DATA_WIDTH-1:0] words_d;
    logic [WORDS*DATA_WIDTH-1:0] words_q;
    logic [SEL_WIDTH-1:0]        sel_q;
    logic                        v_q;

    // 2:1 reduction of the previous level, steered by select bit k-1.
    always_comb begin
      words_d = '0;
      for (int j = 0; j < WORDS; j++) begin
        words_d[j*DATA_WIDTH +: DATA_WIDTH] = lvl_sel[k-1][k-1]
          ? tree[IN_OFF + (2*j+1)*DATA_WIDTH +: DATA_WIDTH]
          : tree[IN_OFF + (2*j)*DATA_WIDTH   +: DATA_WIDTH];
      end
    end

    // Stage register: valid follows upstream on advance; payload loads only
    // with a real word so the output holds its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: payload is reset too, so o and o_sel read 0 after reset
        // rather than stale data; it is a handful of flops, not a RAM.
        v_q     <= 1'b0;
        words_q <= '0;
        sel_q   <= '0;
      end else if (adv[k]) begin
        // NOTE: non-blocking so every stage samples its predecessor's value
        // from before this edge; blocking would collapse the pipeline.
        v_q <= lvl_v[k-1];
        if (lvl_v[k-1]) begin
          words_q <= words_d;
          sel_q   <= lvl_sel[k-1];
        end
      end
    end

    assign adv[k]                        = !v_q || adv[k+1];
    assign tree[Q_OFF +: WORDS*DATA_WIDTH] = words_q;
    assign lvl_sel[k]                    = sel_q;
    assign lvl_v[k]                      = v_q;
  end

endmodule

// File: tb/tb_block_mux_pipe.sv
// Self-checking bench for block_mux_pipe (SEL_WIDTH = 2, DATA_WIDTH = 8).
// A queue model of accepted words checks every output transfer, the
// o_ready rule and output hold; directed sequences pin exact cycle timing.
module tb_block_mux_pipe;
  localparam int SW = 2;
  localparam int DW = 8;

  logic clk;
  logic rst;

  block_mux_pipe_if #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  block_mux_pipe #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: words in flight, oldest first ----------------
  logic [SW+DW-1:0] q[$];
  logic             hold_en;
  logic             prev_xfer, prev_ov;
  logic [DW-1:0]    prev_o;
  logic [SW-1:0]    prev_sel;

  always @(negedge clk or posedge rst) begin
    logic             ok;
    logic [SW+DW-1:0] e;
    if (rst) begin
      q.delete();
      hold_en = 1'b0;
    end else begin
      if (hold_en && !prev_xfer) begin
        ok = prev_ov ? (bus.o_valid && bus.o == prev_o && bus.o_sel == prev_sel)
                     : (bus.o_valid || (bus.o == prev_o && bus.o_sel == prev_sel));
        check("hold", {31'd0, ok}, 32'd1);
      end
      // Ready unless the sink stalls with every stage occupied.
      check("o_ready_rule", {31'd0, bus.o_ready},
            {31'd0, (bus.i_ready || q.size() < SW)});
      if (bus.o_valid && bus.i_ready) begin
        check("out_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("model_o", {24'd0, bus.o}, {24'd0, e[DW-1:0]});
          check("model_o_sel", {30'd0, bus.o_sel}, {30'd0, e[SW+DW-1:DW]});
        end
      end
      if (bus.i_valid && bus.o_ready)
        q.push_back({bus.I_sel, bus.I[bus.I_sel*DW +: DW]});
      prev_xfer = bus.o_valid && bus.i_ready;
      prev_ov   = bus.o_valid;
      prev_o    = bus.o;
      prev_sel  = bus.o_sel;
      hold_en   = 1'b1;
    end
  end

  // ---------------- directed source with per-cycle recording ----------------
  logic          rec_ov   [16];
  logic [DW-1:0] rec_o    [16];
  logic [SW-1:0] rec_sel  [16];
  logic          rec_ordy [16];
  int            rec_idx  [16];

  // words: 2-bit selects, word w at [2w+:2]; offer/rdy: one bit per cycle.
  task automatic run_seq(input int n, input int nw, input logic [15:0] words,
                         input logic [15:0] offer, input logic [15:0] rdy);
    int idx;
    idx = 0;
    for (int c = 0; c < n; c++) begin
      bus.i_ready = rdy[c];
      bus.i_valid = offer[c] && (idx < nw);
      bus.I_sel   = (idx < nw) ? words[idx*2 +: 2] : 2'd0;
      @(negedge clk);
      rec_ov[c]   = bus.o_valid;
      rec_o[c]    = bus.o;
      rec_sel[c]  = bus.o_sel;
      rec_ordy[c] = bus.o_ready;
      rec_idx[c]  = idx;
      if (bus.i_valid && bus.o_ready) idx++;
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
  endtask

  logic [DW-1:0] stream_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst         = 1'b1;
    bus.I       = 32'h44332211;
    bus.I_sel   = 2'd0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_o", {24'd0, bus.o}, 32'h00);
    check("rst_o_sel", {30'd0, bus.o_sel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_o_ready", {31'd0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single word on channel 2: visible exactly two cycles after acceptance.
    run_seq(5, 1, 16'h0002, 16'h0001, 16'hffff);
    for (int c = 0; c < 5; c++)
      check($sformatf("single_ov[%0d]", c), {31'd0, rec_ov[c]}, {31'd0, c == 2});
    check("single_o", {24'd0, rec_o[2]}, 32'h33);
    check("single_o_sel", {30'd0, rec_sel[2]}, 32'd2);
    check("single_hold", {24'd0, rec_o[3]}, 32'h33);

    // Streaming 0,1,2,3 back to back.
    run_seq(8, 4, 16'h00e4, 16'hffff, 16'hffff);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("stream_ov[%0d]", c), {31'd0, rec_ov[c]},
            {31'd0, (c >= 2 && c <= 5)});
      if (c >= 2 && c <= 5) begin
        check($sformatf("stream_o[%0d]", c), {24'd0, rec_o[c]},
              {24'd0, stream_exp[c-2]});
        check($sformatf("stream_sel[%0d]", c), {30'd0, rec_sel[c]}, c - 2);
      end
    end

    // Backpressure: sink stalled for 4 cycles while 3,2,1,0 are offered.
    run_seq(10, 4, 16'h001b, 16'hffff, 16'hfff0);
    check("bp_accepted", rec_idx[3], 2);
    check("bp_ordy2", {31'd0, rec_ordy[2]}, 32'd0);
    check("bp_ordy3", {31'd0, rec_ordy[3]}, 32'd0);
    check("bp_ordy4", {31'd0, rec_ordy[4]}, 32'd1);
    check("bp_stall_o2", {24'd0, rec_o[2]}, 32'h44);
    check("bp_stall_o3", {24'd0, rec_o[3]}, 32'h44);
    for (int c = 4; c < 8; c++) begin
      check($sformatf("bp_ov[%0d]", c), {31'd0, rec_ov[c]}, 32'd1);
      check($sformatf("bp_o[%0d]", c), {24'd0, rec_o[c]},
            {24'd0, stream_exp[7-c]});
    end
    check("bp_end_ov", {31'd0, rec_ov[8]}, 32'd0);
    check("drained", q.size(), 0);

    // Bubbles: sel 1, gap, sel 3.
    run_seq(6, 2, 16'h000d, 16'h0005, 16'hffff);
    check("bub_ov2", {31'd0, rec_ov[2]}, 32'd1);
    check("bub_ov3", {31'd0, rec_ov[3]}, 32'd0);
    check("bub_ov4", {31'd0, rec_ov[4]}, 32'd1);
    check("bub_o2", {24'd0, rec_o[2]}, 32'h22);
    check("bub_o3", {24'd0, rec_o[3]}, 32'h22);
    check("bub_o4", {24'd0, rec_o[4]}, 32'h44);

    // Mid-flight reset with both stages occupied.
    run_seq(2, 2, 16'h0004, 16'h0003, 16'h0000);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ov", {31'd0, bus.o_valid}, 32'd0);
    check("mid_rst_o", {24'd0, bus.o}, 32'h00);
    check("mid_rst_sel", {30'd0, bus.o_sel}, 32'd0);
    #1 rst = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_ov[%0d]", c), {31'd0, bus.o_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
